ltssm_rx_sequencer: RTL and testbench

LTSSM_RX_SEQUENCER -- requirements
Module: ltssm_rx_sequencer

---
 rtl/ltssm_pkg.sv | 34 +++
 rtl/os_run_counter.sv | 28 ++
 rtl/ltssm_rx_sequencer.sv | 134 +++++++++++++
 tb/tb_ltssm_rx_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ltssm_pkg.sv
// ltssm_pkg
//   Shared definitions for the LTSSM receive-side sequencer and its ordered-set
//   checker: substate encoding, L0 code, port-direction encoding and the widths
//   of the run counter and the timeout timer.
package ltssm_pkg;

  typedef enum logic [3:0] {
    DETECT_QUIET          = 4'd0,
    DETECT_ACTIVE         = 4'd1,
    POLLING_ACTIVE        = 4'd2,
    POLLING_CONFIGURATION = 4'd3,
    CFG_LINKWIDTH_START   = 4'd4,
    CFG_LINKWIDTH_ACCEPT  = 4'd5,
    CFG_LANENUM_WAIT      = 4'd6,
    CFG_LANENUM_ACCEPT    = 4'd7,
    CFG_COMPLETE          = 4'd8,
    CFG_IDLE              = 4'd9,
    L0                    = 4'd10
  } substate_t;

  localparam logic [3:0] L0_CODE = 4'd10;

  localparam int DEVTYPE_DOWNSTREAM = 0;
  localparam int DEVTYPE_UPSTREAM   = 1;

  localparam int OS_COUNT_W = 5;
  localparam int TIMER_W    = 25;

  // Substates whose exit is decided by counting ordered sets.
  function automatic logic is_os_state(substate_t s);
    return (s >= POLLING_ACTIVE) && (s <= CFG_IDLE);
  endfunction

endpackage

// File: rtl/os_run_counter.sv
// os_run_counter
//   Length of the current run of consecutive matching ordered sets.
//   Clears to 0 on reset or clear, otherwise increments on countup and
//   saturates at its all-ones value.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the run on this edge
//   countup    : one more matching ordered set
//   count      : current run length
module os_run_counter
  import ltssm_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  countup,
  output logic [OS_COUNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (countup && (count != {OS_COUNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ltssm_rx_sequencer.sv
// ltssm_rx_sequencer
//   Steps the receive-side LTSSM substate from detect through configuration to
//   L0, advancing on a threshold run of matching ordered sets reported by the
//   checker, and resetting the checker for one cycle on every substate change.
//   Optional substate timeout is compiled in with `define LTSSM_SEQ_TIMEOUT_EN.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   rx_detected     : receiver detected / electrical idle exit
//   os_countup      : checker reports one more matching ordered set
//   os_resetcounter : checker run valid (0 clears the run)
//   substate        : current substate, to the checker
//   checker_reset_n : active-low checker reset, low the first cycle of a substate
//   os_count        : current consecutive ordered-set run length
//   link_up         : high while in L0
//   timeout_evt     : one-cycle pulse when a substate times out
//
// state                 | meaning
// DETECT_QUIET          | dwell DETECT_QUIET_CYCLES cycles
// DETECT_ACTIVE         | one cycle: go to polling if a receiver is seen
// POLLING_ACTIVE..IDLE  | advance on OS_THRESHOLD run (downstream skips LW accept)
// L0                    | link up, terminal until reset
module ltssm_rx_sequencer
  import ltssm_pkg::*;
#(
  parameter int DEVICETYPE          = DEVTYPE_DOWNSTREAM,
  parameter int OS_THRESHOLD        = 8,
  parameter int DETECT_QUIET_CYCLES = 16,
  parameter int TIMEOUT_CYCLES      = 24000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_detected,
  input  logic                  os_countup,
  input  logic                  os_resetcounter,
  output logic [3:0]            substate,
  output logic                  checker_reset_n,
  output logic [OS_COUNT_W-1:0] os_count,
  output logic                  link_up,
  output logic                  timeout_evt
);

  localparam int QUIET_W = (DETECT_QUIET_CYCLES > 1) ? $clog2(DETECT_QUIET_CYCLES) : 1;
  localparam logic [QUIET_W-1:0]    QUIET_LAST = QUIET_W'(DETECT_QUIET_CYCLES - 1);
  localparam logic [OS_COUNT_W-1:0] OS_THR     = OS_COUNT_W'(OS_THRESHOLD);

  substate_t          state_q, state_d;
  logic               crn_q;
  logic [QUIET_W-1:0] quiet_q;
  logic               advance;
  logic               timeout_hit;
  logic               state_chg;

  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    case (state_q)
      DETECT_QUIET:  if (quiet_q == QUIET_LAST) state_d = DETECT_ACTIVE;
      DETECT_ACTIVE: state_d = rx_detected ? POLLING_ACTIVE : DETECT_QUIET;
      L0:            state_d = L0;
      default: begin
        // A downstream checker has no accept check, so that substate is a
        // fixed one-cycle pass-through rather than a counted one.
        if ((DEVICETYPE == DEVTYPE_DOWNSTREAM) && (state_q == CFG_LINKWIDTH_ACCEPT)) begin
          advance = 1'b1;
        end else if (crn_q && (os_count == OS_THR)) begin
          advance = 1'b1;
        end
        if (advance) begin
          state_d = substate_t'(state_q + 4'd1);
        end else if (timeout_hit) begin
          state_d = DETECT_QUIET;
        end
      end
    endcase
  end

  assign state_chg = (state_d != state_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DETECT_QUIET;
      crn_q   <= 1'b0;
      quiet_q <= '0;
    end else begin
      state_q <= state_d;
      crn_q   <= ~state_chg;
      quiet_q <= (state_chg || (state_q != DETECT_QUIET)) ? '0 : quiet_q + 1'b1;
    end
  end

`ifdef LTSSM_SEQ_TIMEOUT_EN
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] timer_q;
  logic               tmo_q;

  assign timeout_hit = is_os_state(state_q) && (timer_q == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      timer_q <= (state_chg || !is_os_state(state_q)) ? '0 : timer_q + 1'b1;
      // Advance takes priority, so a same-cycle threshold gives no pulse.
      tmo_q   <= timeout_hit & ~advance;
    end
  end

  assign timeout_evt = tmo_q;
`else
  // No timer: substates wait indefinitely. TIMEOUT_CYCLES stays in the
  // parameter list so both builds instantiate identically.
  localparam bit TIMEOUT_CFG_VALID = (TIMEOUT_CYCLES > 0);

  assign timeout_hit = 1'b0;
  assign timeout_evt = 1'b0 & TIMEOUT_CFG_VALID;
`endif

  // Clearing on the changing edge keeps the count at 0 for the whole cycle
  // the checker is held in reset.
  os_run_counter u_run (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_chg | ~crn_q | ~os_resetcounter),
    .countup (os_countup),
    .count   (os_count)
  );

  assign substate        = state_q;
  assign checker_reset_n = crn_q;
  assign link_up         = (state_q == L0_CODE);

endmodule

// File: tb/tb_ltssm_rx_sequencer.sv
module tb_ltssm_rx_sequencer;

  logic       clk;
  logic       reset0, reset1;
  logic       rx, up, rc;
  logic       sel;
  logic [3:0] sub0, sub1, sub;
  logic       crn0, crn1, crn;
  logic [4:0] cnt0, cnt1, cnt;
  logic       lu0, lu1, lu;
  logic       to0, to1, tov;

  int total = 0;
  int bad   = 0;

  ltssm_rx_sequencer #(
    .DEVICETYPE(0), .OS_THRESHOLD(8), .DETECT_QUIET_CYCLES(16), .TIMEOUT_CYCLES(100)
  ) dut0 (
    .clk(clk), .reset(reset0), .rx_detected(rx), .os_countup(up), .os_resetcounter(rc),
    .substate(sub0), .checker_reset_n(crn0), .os_count(cnt0), .link_up(lu0), .timeout_evt(to0)
  );

  ltssm_rx_sequencer #(
    .DEVICETYPE(1), .OS_THRESHOLD(8), .DETECT_QUIET_CYCLES(16), .TIMEOUT_CYCLES(100)
  ) dut1 (
    .clk(clk), .reset(reset1), .rx_detected(rx), .os_countup(up), .os_resetcounter(rc),
    .substate(sub1), .checker_reset_n(crn1), .os_count(cnt1), .link_up(lu1), .timeout_evt(to1)
  );

  assign sub = sel ? sub1 : sub0;
  assign crn = sel ? crn1 : crn0;
  assign cnt = sel ? cnt1 : cnt0;
  assign lu  = sel ? lu1  : lu0;
  assign tov = sel ? to1  : to0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst, rx, up, rc;
    int   sub, crn, cnt, lu, to;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic x, logic u, logic c,
                              int s, int n, int k, int l, int t);
    vec_t v;
    v.rst = r; v.rx = x; v.up = u; v.rc = c;
    v.sub = s; v.crn = n; v.cnt = k; v.lu = l; v.to = t;
    vecs.push_back(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic advance_to(input int target, input int budget, input string name);
    for (int i = 0; i < budget && int'(sub) != target; i++) step();
    check(name, int'(sub), target);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev, dwell, to_seen;

    sel = 1'b0; reset0 = 1'b1; reset1 = 1'b1;
    rx = 1'b1; up = 1'b0; rc = 1'b1;

    // Detect, polling advance, run restart (downstream instance).
    add(1,1,0,1, 0,0,0,0,0);
    add(1,1,0,1, 0,0,0,0,0);
    for (int k = 1; k <= 15; k++) add(0,1,0,1, 0,1,0,0,0);
    add(0,1,0,1, 1,0,0,0,0);
    add(0,1,0,1, 2,0,0,0,0);
    add(0,1,0,1, 2,1,0,0,0);
    for (int k = 1; k <= 8; k++) add(0,1,1,1, 2,1,k,0,0);
    add(0,1,0,1, 3,0,0,0,0);
    add(0,1,0,1, 3,1,0,0,0);
    for (int k = 1; k <= 5; k++) add(0,1,1,1, 3,1,k,0,0);
    add(0,1,0,0, 3,1,0,0,0);
    for (int k = 1; k <= 8; k++) add(0,1,1,1, 3,1,k,0,0);
    add(0,1,0,1, 4,0,0,0,0);

    foreach (vecs[i]) begin
      reset0 = vecs[i].rst; rx = vecs[i].rx; up = vecs[i].up; rc = vecs[i].rc;
      step();
      check($sformatf("vec%0d_sub", i), int'(sub), vecs[i].sub);
      check($sformatf("vec%0d_crn", i), int'(crn), vecs[i].crn);
      check($sformatf("vec%0d_cnt", i), int'(cnt), vecs[i].cnt);
      check($sformatf("vec%0d_lu",  i), int'(lu),  vecs[i].lu);
      check($sformatf("vec%0d_to",  i), int'(tov), vecs[i].to);
    end

    // Downstream: link-width accept lasts exactly one cycle.
    up = 1'b1;
    advance_to(5, 20, "ds_reach_lw_accept");
    step();
    check("ds_lw_accept_one_cycle", int'(sub), 6);
    check("ds_lanenum_wait_crn", int'(crn), 0);

    // Threshold reached on the same cycle the timer expires: advance, no pulse.
    to_seen = 0;
    for (int n = 0; n < 100; n++) begin
      up = (n >= 91 && n <= 98);
      step();
      to_seen += int'(tov);
      if (n == 98) begin
        check("same_cycle_cnt", int'(cnt), 8);
        check("same_cycle_sub_before", int'(sub), 6);
      end
    end
    check("same_cycle_advance", int'(sub), 7);
    check("same_cycle_no_pulse", to_seen, 0);

    // Upstream instance: detectActive without a receiver falls back to quiet.
    sel = 1'b1; up = 1'b0; rx = 1'b0;
    reset1 = 1'b1; step(); step();
    reset1 = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      step();
      if (n == 16) check("us_detect_active", int'(sub), 1);
    end
    check("us_no_rx_back_quiet", int'(sub), 0);
    check("us_no_rx_crn", int'(crn), 0);

    rx = 1'b1; up = 1'b1;
    advance_to(2, 40, "us_reach_polling");

    // Full traversal 2..10, ten cycles per counted substate.
    prev = 2; dwell = 0; to_seen = 0;
    for (int i = 0; i < 150 && int'(sub) != 10; i++) begin
      step();
      dwell++;
      to_seen += int'(tov);
      if (int'(sub) != prev) begin
        check($sformatf("us_order_from_%0d", prev), int'(sub), prev + 1);
        check($sformatf("us_dwell_in_%0d", prev), dwell, 10);
        prev = int'(sub);
        dwell = 0;
      end
    end
    check("us_reach_l0", int'(sub), 10);
    check("us_link_up", int'(lu), 1);
    check("us_no_timeout", to_seen, 0);

    // L0 is terminal; the run counter saturates at 31.
    for (int i = 0; i < 40; i++) step();
    check("l0_hold", int'(sub), 10);
    check("l0_link_up", int'(lu), 1);
    check("l0_cnt_saturate", int'(cnt), 31);

    // Reset while in L0.
    reset1 = 1'b1;
    step();
    check("l0_reset_sub", int'(sub), 0);
    check("l0_reset_lu", int'(lu), 0);
    check("l0_reset_cnt", int'(cnt), 0);
    check("l0_reset_crn", int'(crn), 0);
    reset1 = 1'b0;

    // No ordered sets in cfgLanenumWait.
    advance_to(6, 200, "us_reach_lanenum_wait");
    up = 1'b0;
    to_seen = 0;
    for (int n = 1; n <= 99; n++) begin
      step();
      to_seen += int'(tov);
    end
    check("tmo_still_waiting", int'(sub), 6);
    check("tmo_no_early_pulse", to_seen, 0);
    step();
`ifdef LTSSM_SEQ_TIMEOUT_EN
    check("tmo_to_quiet", int'(sub), 0);
    check("tmo_pulse", int'(tov), 1);
    step();
    check("tmo_pulse_one_cycle", int'(tov), 0);
    check("tmo_stay_quiet", int'(sub), 0);
`else
    check("tmo_disabled_wait", int'(sub), 6);
    check("tmo_disabled_no_pulse", int'(tov), 0);
    step();
    check("tmo_disabled_no_pulse2", int'(tov), 0);
    check("tmo_disabled_wait2", int'(sub), 6);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
